cdc_handshake_rx: RTL
=====================

Name: cdc_handshake_rx

Overview:
- Destination-domain receiver for the toggle req/ack CDC protocol.
- Consumes the synchronized request toggle produced by the two-stage synchronizer (cdc_sync_dff, NUM_SYNC_STAGES=2, DATA_WIDTH=1) and captures the source-held data bus.
- Presents the captured word on a valid/ready stream and returns an acknowledge toggle to the source domain.
- Sits between the synchronizer output and destination-side consumers (e.g. config registers of the PSK modulator).

Parameters:
- DATA_WIDTH, 8, width of the transferred word.
- CNT_WIDTH, 16, width of the completed-transfer counter.

Ports:
- clk_dest  input  1  destination clock; single clock for the whole block.
- rst_n  input  1  synchronous, active-low reset, sampled on posedge clk_dest.
- req_sync  input  1  request toggle, already synchronized into clk_dest.
- data_async  input  DATA_WIDTH  source-domain data; source holds it stable from req toggle until ack toggle.
- ack_toggle  output  1  acknowledge toggle to source; direct flop output, no logic after it.
- m_data  output  DATA_WIDTH  captured word.
- m_valid  output  1  m_data valid.
- m_ready  input  1  consumer accepts when m_valid && m_ready.
- err_overrun  output  1  sticky protocol-violation flag.
- xfer_cnt  output  CNT_WIDTH  completed-transfer count.

Behaviour:
- Internal req_q holds the last seen req_sync. Event = req_sync ^ req_q.
- Reset (rst_n=0 at a clock edge):
  - req_q <= req_sync and ack_toggle <= req_sync, so there is no spurious event on reset release.
  - m_valid=0, m_data=0, err_overrun=0, xfer_cnt=0, state=IDLE.
- State IDLE:
  - On event at edge N: m_data <= data_async, m_valid <= 1, req_q <= req_sync, state <= HOLD.
  - m_valid is visible after edge N (1-cycle latency from req_sync change).
- State HOLD:
  - m_data stable; m_valid held at 1 until accepted.
  - When m_valid && m_ready at edge K: m_valid <= 0, ack_toggle <= ~ack_toggle, xfer_cnt <= xfer_cnt+1, state <= IDLE.
  - A new event is accepted at edge K+1 at the earliest.
- m_ready already high when m_valid rises: m_valid is a 1-cycle pulse and ack toggles at the next edge.
- Event while in HOLD (source toggled twice without ack):
  - err_overrun <= 1 (sticky until reset).
  - req_q <= req_sync; the event is absorbed.
  - m_data and m_valid unchanged; no capture.
- Event and acceptance on the same edge in HOLD: acceptance completes (ack toggles, count increments) and err_overrun is set. The new word is not captured.
- xfer_cnt wraps from 2^CNT_WIDTH-1 to 0 without flagging.
- Reset mid-transfer (HOLD): m_valid drops and ack_toggle realigns to req_sync. The source sees the transfer as acknowledged; the word is dropped.
- ack_toggle changes only on acceptance or reset; never combinational.
- No X propagation: data_async is captured only on an event in IDLE.

Decomposition:
- Shared package cdc_pkg (include file) holds:
  - State encoding constants: IDLE=1'b0, HOLD=1'b1.
  - Default sync depth constant CDC_SYNC_STAGES=2.
- No sub-module required. The toggle edge detect is inline (one flop plus XOR).
- The synchronizer is instantiated by the parent, not inside this block.

Test Plan:
- Reset release with req_sync=1: hold rst_n=0 for 3 cycles, then release -> ack_toggle=1, m_valid=0, no capture, err_overrun=0, xfer_cnt=0.
- Single transfer: data_async=8'hA5, toggle req_sync 0->1, m_ready=0 for 4 cycles then 1 -> m_valid rises 1 cycle after the toggle with m_data=8'hA5 and stays 1 for 5 cycles; ack_toggle flips 0->1 at the acceptance edge; xfer_cnt=1.
- Back-to-back with m_ready tied high: words 8'h01, 8'h02, 8'h03, each toggle sent after the previous ack -> three 1-cycle m_valid pulses carrying 01/02/03, ack toggles 3 times, xfer_cnt=3, err_overrun=0.
- Overrun: toggle req_sync twice while in HOLD with m_ready=0 -> err_overrun=1 and stays 1; m_data keeps the first word; after m_ready=1 exactly one acceptance and xfer_cnt increments by 1.
- Counter wrap: CNT_WIDTH=4, run 17 transfers -> xfer_cnt reads 15 after 15 transfers, 0 after 16, 1 after 17.
- Reset in HOLD: capture 8'h5A, assert rst_n=0 before m_ready -> m_valid=0 and ack_toggle equals req_sync after the reset edge; after release there is no m_valid until the next req toggle.

Source files
------------

// File: rtl/cdc_handshake_rx_pkg.sv
// Shared definitions for the toggle req/ack CDC receiver.
//   rx_state_t      : receiver FSM encoding (IDLE waits for a request, HOLD presents a word)
//   CDC_SYNC_STAGES : default depth of the req synchronizer placed by the parent
package cdc_handshake_rx_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } rx_state_t;

    localparam int unsigned CDC_SYNC_STAGES = 2;

endpackage

// File: rtl/cdc_handshake_rx_if.sv
// Handshake bundle between the CDC request/acknowledge path, the source data bus
// and the destination valid/ready stream.
//   req_sync   : request toggle, already synchronized into the destination clock
//   data_async : source-held data word
//   ack_toggle : acknowledge toggle back to the source domain
//   m_data     : captured word
//   m_valid    : m_data valid
//   m_ready    : consumer accepts when m_valid && m_ready
// Modports:
//   slave  : the receiver (cdc_handshake_rx)
//   master : the surrounding logic (synchronizer output, source bus, consumer)
interface cdc_handshake_rx_if #(
    parameter int unsigned DATA_WIDTH = 8
);

    logic                  req_sync;
    logic [DATA_WIDTH-1:0] data_async;
    logic                  ack_toggle;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_valid;
    logic                  m_ready;

    modport slave (
        input  req_sync,
        input  data_async,
        input  m_ready,
        output ack_toggle,
        output m_data,
        output m_valid
    );

    modport master (
        output req_sync,
        output data_async,
        output m_ready,
        input  ack_toggle,
        input  m_data,
        input  m_valid
    );

endinterface

// File: rtl/cdc_handshake_rx.sv
// Destination-domain receiver for the toggle req/ack CDC protocol.
// A change on the synchronized request toggle captures the source-held data word,
// which is presented on a valid/ready stream. Acceptance of the word flips the
// acknowledge toggle returned to the source and bumps the transfer counter.
// Ports:
//   clk_dest    : destination clock
//   rst_n       : synchronous active-low reset
//   hs          : handshake bundle (slave side), see cdc_handshake_rx_if
//   err_overrun : sticky flag, set when a request arrives while a word is still held
//   xfer_cnt    : completed-transfer count, wraps silently
module cdc_handshake_rx
    import cdc_handshake_rx_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                 clk_dest,
    input  logic                 rst_n,
    cdc_handshake_rx_if.slave    hs,
    output logic                 err_overrun,
    output logic [CNT_WIDTH-1:0] xfer_cnt
);

    rx_state_t             state_q, state_d;
    logic                  req_q, req_d;
    logic                  ack_q, ack_d;
    logic                  valid_q, valid_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  err_q, err_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  req_event;

    assign req_event = hs.req_sync ^ req_q;

    // Reset aligns both req_q and the ack toggle to the current request level,
    // so release never produces a spurious event and an in-flight transfer is
    // seen by the source as acknowledged.
    always_ff @(posedge clk_dest) begin
        if (!rst_n) begin
            state_q <= IDLE;
            req_q   <= hs.req_sync;
            ack_q   <= hs.req_sync;
            valid_q <= 1'b0;
            data_q  <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            ack_q   <= ack_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        ack_d   = ack_q;
        valid_d = valid_q;
        data_d  = data_q;
        err_d   = err_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            IDLE: begin
                // data_async is only sampled here, so an undriven bus between
                // transfers never reaches m_data.
                if (req_event) begin
                    data_d  = hs.data_async;
                    valid_d = 1'b1;
                    req_d   = hs.req_sync;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (valid_q && hs.m_ready) begin
                    valid_d = 1'b0;
                    ack_d   = ~ack_q;
                    cnt_d   = cnt_q + 1'b1;
                    state_d = IDLE;
                end
                // A second request before the ack is absorbed without capture;
                // it may coincide with acceptance, which still completes.
                if (req_event) begin
                    err_d = 1'b1;
                    req_d = hs.req_sync;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign hs.ack_toggle = ack_q;
    assign hs.m_valid    = valid_q;
    assign hs.m_data     = data_q;
    assign err_overrun   = err_q;
    assign xfer_cnt      = cnt_q;

endmodule
